// File: rtl/uart_tx_controller.sv
// -----------------------------------------------------------------------------
// uart_tx_controller
//
// Memory-mapped UART transmitter. The CPU queues bytes into a small FIFO via
// the data bus; an FSM drains the FIFO and sends each byte as an 8N1 frame
// (8E1 when UART_TX_PARITY_EN is defined) on uart_tx.
//
// Register map (selected by data_addr[2]):
//   0 TXDATA  write: push data_in[7:0]; read: 0
//   1 STATUS  read : {23'b0, parity_en, level[3:0], overflow, empty, full, busy}
//             write: data_in[3]=1 clears overflow
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   data_addr     local byte address within the device
//   data_in       CPU write data
//   write_enable  write strobe, already qualified by the device decode
//   window_size   access width (unused for register select)
//   data_out      registered read data, valid one cycle after the address
//   uart_tx       serial line, idle high, driven from a register
//
// Build option: define UART_TX_PARITY_EN to add an even-parity bit.
// -----------------------------------------------------------------------------
module uart_tx_controller #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  data_addr,
    input  logic [31:0] data_in,
    input  logic        write_enable,
    input  logic [1:0]  window_size,
    output logic [31:0] data_out,
    output logic        uart_tx
);

    localparam int BAUD_DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = $clog2(BAUD_DIV + 1);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
`else
    localparam logic PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, overflow;
    logic        push_req, push, pop;
    logic        clr_req;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push_req = write_enable && !data_addr[2];
    assign clr_req  = write_enable && data_addr[2] && data_in[3];
    // A full FIFO still accepts a push when the launcher pops the same cycle.
    assign push     = push_req && (!full || pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full && !pop) overflow <= 1'b1;
            else if (clr_req)             overflow <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= data_in[7:0];
    end

    // ---------------------------------------------------------------- FSM
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_d;
    logic            baud_end;
    logic [7:0]      head;

    assign head     = mem[rd_ptr[AW-1:0]];
    assign baud_end = (cnt_q == CW'(BAUD_DIV - 1));

`ifdef UART_TX_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   par_q <= 1'b0;
        else if (pop) par_q <= ^head;
    end
`endif

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
        // tx_d is the line value for the next cycle, so uart_tx can be a plain
        // register that switches on the same edge as the state.
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (baud_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    tx_d    = shift_q[1];
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_d = par_q;
                if (baud_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            uart_tx <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            uart_tx <= tx_d;
        end
    end

    // ---------------------------------------------------------------- bus
    logic [6:0]  level_ext;
    logic [3:0]  level_sat;
    logic        busy;
    logic [31:0] status;

    assign level_ext = 7'(wr_ptr - rd_ptr);
    assign level_sat = (level_ext > 7'd15) ? 4'hF : level_ext[3:0];
    assign busy      = (state_q != S_IDLE) || !empty;
    assign status    = {23'b0, PARITY_FLAG, level_sat, overflow, empty, full, busy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_out <= '0;
        else        data_out <= data_addr[2] ? status : 32'h0;
    end

    // Address low bits, access width and upper write data play no role here.
    logic unused_bits;
    assign unused_bits = ^{data_addr[1:0], window_size, data_in[31:8]};

endmodule

// File: tb/tb_uart_tx_controller.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_controller
//
// Directed bench for uart_tx_controller with CLK_FREQ=1000, BAUD_RATE=100
// (10 clocks per bit) and an 8-entry FIFO. Inputs change and outputs are
// sampled on the falling clock edge; the line and the STATUS read-back are
// logged every cycle and compared against hand-derived frame waveforms.
// Define UART_TX_PARITY_EN for both files to exercise the 8E1 build.
// -----------------------------------------------------------------------------
module tb_uart_tx_controller;

    localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
    localparam int          NB = 11;
    localparam logic [31:0] PF = 32'h100;
`else
    localparam int          NB = 10;
    localparam logic [31:0] PF = 32'h000;
`endif
    localparam int P = BD * NB + 1;  // start-to-start period of queued frames

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  data_addr = 3'd4;
    logic [31:0] data_in = '0;
    logic        write_enable = 1'b0;
    logic [1:0]  window_size = 2'b10;
    logic [31:0] data_out;
    logic        uart_tx;

    uart_tx_controller #(
        .CLK_FREQ  (1000),
        .BAUD_RATE (100),
        .FIFO_DEPTH(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_addr   (data_addr),
        .data_in     (data_in),
        .write_enable(write_enable),
        .window_size (window_size),
        .data_out    (data_out),
        .uart_tx     (uart_tx)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [119:0] got, input logic [119:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t wr_q[$];

    logic        line_log [0:1299];
    logic [31:0] stat_log [0:1299];

    // Starting at a falling edge, log line/status each cycle, then apply the
    // write scheduled for that cycle (default: idle STATUS read).
    task automatic run(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            line_log[c]  = uart_tx;
            stat_log[c]  = data_out;
            write_enable = 1'b0;
            data_addr    = 3'd4;
            data_in      = '0;
            foreach (wr_q[i]) begin
                if (wr_q[i].cyc == c) begin
                    write_enable = 1'b1;
                    data_addr    = wr_q[i].addr;
                    data_in      = wr_q[i].data;
                end
            end
            @(negedge clk);
        end
        write_enable = 1'b0;
        data_addr    = 3'd4;
        wr_q.delete();
    endtask

    task automatic push_wr(input int cyc, input logic [2:0] addr, input logic [31:0] data);
        wr_t w;
        w.cyc  = cyc;
        w.addr = addr;
        w.data = data;
        wr_q.push_back(w);
    endtask

    // Bit k of a frame: 0 start, 1..8 data LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic check_frame(input string tag, input int start, input logic [7:0] b);
        logic [119:0] got, exp;
        got = '0;
        exp = '0;
        for (int j = 0; j < BD * NB; j++) begin
            got[j] = line_log[start + j];
            exp[j] = frame_bit(b, j / BD);
        end
        check(tag, got, exp);
    endtask

    function automatic int count_low(input int from, input int to);
        int n = 0;
        for (int j = from; j < to; j++) if (line_log[j] !== 1'b1) n++;
        return n;
    endfunction

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check("rst_line_async", 120'(uart_tx), 120'(1'b1));
        @(negedge clk);
        check("rst_data_out", 120'(data_out), 120'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset and idle
        repeat (2) @(negedge clk);
        check("reset_line", 120'(uart_tx), 120'(1'b1));
        check("reset_data_out", 120'(data_out), 120'h0);
        rst_n = 1'b1;
        @(negedge clk);
        run(4);
        check("idle_status", 120'(stat_log[3]), 120'(32'h4 | PF));
        check("idle_line", 120'(count_low(0, 4)), 120'h0);
        data_addr = 3'd0;
        @(negedge clk);
        check("txdata_read", 120'(data_out), 120'h0);
        data_addr = 3'd4;
        @(negedge clk);

        // ---------------- single byte 0x55
        push_wr(0, 3'd0, 32'hAABB_CC55);
        run(BD * NB + 10);
        check("latency_pre", 120'(line_log[1]), 120'(1'b1));
        check_frame("frame_55", 2, 8'h55);
        check("busy_mid", 120'(stat_log[50]), 120'(32'h5 | PF));
        check("busy_last", 120'(stat_log[2 + BD * NB]), 120'(32'h5 | PF));
        check("busy_drop", 120'(stat_log[3 + BD * NB]), 120'(32'h4 | PF));

        // ---------------- back-to-back 0x41 0x42 0x43
        push_wr(0, 3'd0, 32'h41);
        push_wr(1, 3'd1, 32'h42);
        push_wr(2, 3'd3, 32'h43);
        run(2 + 3 * P + 10);
        check_frame("frame_41", 2, 8'h41);
        check_frame("frame_42", 2 + P, 8'h42);
        check_frame("frame_43", 2 + 2 * P, 8'h43);
        check("gap_idle", 120'(line_log[1 + P]), 120'(1'b1));
        check("after_abc_idle", 120'(count_low(2 + 3 * P - 1, 2 + 3 * P + 10)), 120'h0);

        // ---------------- overflow: 9 pushes while the line is busy
        push_wr(0, 3'd0, 32'h11);
        for (int i = 0; i < 9; i++) push_wr(3 + i, 3'd0, 32'h20 + i);
        run(2 + 9 * P + 100);
        check("ovf_status", 120'(stat_log[14]), 120'(32'h8B | PF));
        check_frame("ovf_frame_11", 2, 8'h11);
        check_frame("ovf_frame_20", 2 + P, 8'h20);
        check_frame("ovf_frame_23", 2 + 4 * P, 8'h23);
        check_frame("ovf_frame_27", 2 + 8 * P, 8'h27);
        check("ovf_no_9th", 120'(count_low(2 + 9 * P - 1, 2 + 9 * P + 100)), 120'h0);
        check("ovf_sticky", 120'(stat_log[2 + 9 * P + 99]), 120'(32'hC | PF));
        push_wr(0, 3'd4, 32'h7);
        run(4);
        check("ovf_keep_bit3_0", 120'(stat_log[3]), 120'(32'hC | PF));
        push_wr(0, 3'd4, 32'h8);
        run(4);
        check("ovf_clear", 120'(stat_log[3]), 120'(32'h4 | PF));

        // ---------------- reset during data bit 4 of 0xFF, 0x00 queued behind
        push_wr(0, 3'd0, 32'hFF);
        push_wr(1, 3'd0, 32'h00);
        run(56);
        do_reset();
        run(2 * P);
        check("rst_no_residual", 120'(count_low(0, 2 * P)), 120'h0);
        check("rst_fifo_empty", 120'(stat_log[2 * P - 1]), 120'(32'h4 | PF));

        // ---------------- reset during a start bit
        push_wr(0, 3'd0, 32'h00);
        run(6);
        check("start_low", 120'(line_log[5]), 120'(1'b0));
        do_reset();
        run(20);
        check("rst2_idle", 120'(count_low(0, 20)), 120'h0);

`ifdef UART_TX_PARITY_EN
        // ---------------- even parity frames
        push_wr(0, 3'd0, 32'h07);
        push_wr(1, 3'd0, 32'h03);
        run(2 + 2 * P + 10);
        check_frame("par_frame_07", 2, 8'h07);
        check_frame("par_frame_03", 2 + P, 8'h03);
        check("par_bit_07", 120'(line_log[2 + 95]), 120'(1'b1));
        check("par_bit_03", 120'(line_log[2 + P + 95]), 120'(1'b0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
